ex_alu_mdu: RTL and testbench

Parametrised successor to the single-cycle EX-stage ALU. It keeps the combinational integer ops and adds a sequential multiply/divide unit (MDU) with architectural HI/LO registers. A stall handshake holds the pipeline while an iterative multiply or divide runs. It sits in the EX stage between the ID/EX register and the EX/MEM register and drives the ALU result, the Zero flag and a stall request to the hazard unit.

---
 rtl/ex_alu_pkg.sv | 48 ++++
 rtl/ex_mdu_seq.sv | 139 +++++++++++++
 rtl/ex_alu_mdu.sv | 90 +++++++++
 tb/tb_ex_alu_mdu.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_pkg.sv
// ex_alu_pkg: op encodings, MDU state enum and decode helpers shared by ex_alu_mdu.
// Divider decode is compiled in only when EX_ALU_MDU_DIV_EN is defined.
package ex_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_MULT  = 4'b1001,
    OP_MULTU = 4'b1010,
    OP_DIV   = 4'b1011,
    OP_NOR   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_MFHI  = 4'b1110,
    OP_MFLO  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam int unsigned MAX_WIDTH = 128;
  localparam logic [MAX_WIDTH-1:0] DIV_BY_ZERO_LO = '1;

  function automatic logic is_mdu_launch_op(input logic [3:0] op);
    logic hit;
    hit = (op == OP_MULT) || (op == OP_MULTU);
`ifdef EX_ALU_MDU_DIV_EN
    hit = hit || (op == OP_DIV) || (op == OP_DIVU);
`endif
    return hit;
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_seq.sv
// ex_mdu_seq: iterative radix-2 multiply/divide unit owning HI/LO.
// Restoring divider is present only when EX_ALU_MDU_DIV_EN is defined.
module ex_mdu_seq
  import ex_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   shr_q, shr_d;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_q;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef EX_ALU_MDU_DIV_EN
  logic               div_q, neg_rem_q, dz_q;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

  // Signed ops run on magnitudes; the sign is restored in DONE.
  always_comb begin
    a_neg = is_signed_op(op_i) & a_i[WIDTH-1];
    b_neg = is_signed_op(op_i) & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  always_comb begin
    mul_sum = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
    acc_d   = mul_sum[WIDTH:1];
    shr_d   = {mul_sum[0], shr_q[WIDTH-1:1]};
`ifdef EX_ALU_MDU_DIV_EN
    div_shift = {acc_q, shr_q[WIDTH-1]};
    if (div_q) begin
      if (div_shift >= {1'b0, opb_q}) begin
        acc_d = WIDTH'(div_shift - {1'b0, opb_q});
        shr_d = {shr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift[WIDTH-1:0];
        shr_d = {shr_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign prod_fix = neg_q ? -{acc_q, shr_q} : {acc_q, shr_q};
`ifdef EX_ALU_MDU_DIV_EN
  // Remainder follows the dividend sign, which also yields HI = dividend on divide by zero.
  assign quo_fix = dz_q ? DIV_BY_ZERO_LO[WIDTH-1:0] : (neg_q ? -shr_q : shr_q);
  assign rem_fix = neg_rem_q ? -acc_q : acc_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shr_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef EX_ALU_MDU_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            state_q   <= MDU_RUN;
            cnt_q     <= CNT_W'(WIDTH);
            acc_q     <= '0;
            shr_q     <= a_mag;
            opb_q     <= b_mag;
            neg_q     <= a_neg ^ b_neg;
`ifdef EX_ALU_MDU_DIV_EN
            div_q     <= is_div_op(op_i);
            neg_rem_q <= a_neg;
            dz_q      <= is_div_op(op_i) && (b_i == '0);
`endif
          end
        end
        MDU_RUN: begin
          if (flush_i) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            shr_q <= shr_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          state_q <= MDU_IDLE;
          if (!flush_i) begin
`ifdef EX_ALU_MDU_DIV_EN
            if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
`else
            {hi_q, lo_q} <= prod_fix;
`endif
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != MDU_IDLE);

endmodule

// File: rtl/ex_alu_mdu.sv
// ex_alu_mdu: EX-stage ALU with combinational ops and a stalling multiply/divide unit.
// Define EX_ALU_MDU_DIV_EN to build the divider; otherwise DIV/DIVU decode as illegal.
module ex_alu_mdu
  import ex_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Read_Data_1_EX,
  input  logic [WIDTH-1:0] ALU_Data_2_EX,
  input  logic [3:0]       ALU_Control_EX,
  input  logic             Valid_EX,
  input  logic             Flush_EX,
  output logic [WIDTH-1:0] ALU_Result_EX,
  output logic             Zero_EX,
  output logic             Stall_EX,
  output logic             Illegal_EX
);

  if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("ex_alu_mdu: WIDTH must be even and at least 8");
  end

  logic [WIDTH-1:0] and_v, or_v, nor_v;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;
  logic             slt_lt, sltu_lt;
  logic             bad_op;
  logic             mdu_launch, mdu_busy;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
    assign and_v[gi] = Read_Data_1_EX[gi] & ALU_Data_2_EX[gi];
    assign or_v[gi]  = Read_Data_1_EX[gi] | ALU_Data_2_EX[gi];
    assign nor_v[gi] = ~or_v[gi];
  end

  assign slt_lt  = $signed(Read_Data_1_EX) < $signed(ALU_Data_2_EX);
  assign sltu_lt = Read_Data_1_EX < ALU_Data_2_EX;

  always_comb begin
    alu_result = '0;
    bad_op     = 1'b0;
    case (ALU_Control_EX)
      OP_ADD:            alu_result = Read_Data_1_EX + ALU_Data_2_EX;
      OP_SUB:            alu_result = Read_Data_1_EX - ALU_Data_2_EX;
      OP_AND:            alu_result = and_v;
      OP_OR:             alu_result = or_v;
      OP_NOR:            alu_result = nor_v;
      OP_SLT:            alu_result = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_SLTU:           alu_result = {{(WIDTH-1){1'b0}}, sltu_lt};
      OP_MULT, OP_MULTU: alu_result = '0;
      OP_DIV, OP_DIVU: begin
`ifdef EX_ALU_MDU_DIV_EN
        alu_result = '0;
`else
        bad_op = 1'b1;
`endif
      end
      OP_MFHI:           alu_result = mdu_hi;
      OP_MFLO:           alu_result = mdu_lo;
      default:           bad_op = 1'b1;
    endcase
  end

  // A flush in the same cycle suppresses the launch.
  assign mdu_launch = Reset_n & Valid_EX & ~Flush_EX & is_mdu_launch_op(ALU_Control_EX);

  ex_mdu_seq #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .start_i(mdu_launch),
    .flush_i(Flush_EX),
    .op_i   (ALU_Control_EX),
    .a_i    (Read_Data_1_EX),
    .b_i    (ALU_Data_2_EX),
    .hi_o   (mdu_hi),
    .lo_o   (mdu_lo),
    .busy_o (mdu_busy)
  );

  assign ALU_Result_EX = alu_result;
  assign Zero_EX       = (alu_result == '0);
  assign Illegal_EX    = Reset_n & Valid_EX & bad_op;
  // Busy spans RUN and DONE, which also covers the MFHI/MFLO interlock.
  assign Stall_EX      = Reset_n & (mdu_launch | mdu_busy);

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Self-checking bench for ex_alu_mdu: vector table, scripted MDU corner cases, random ops vs a model.
// Expectations adapt to whether EX_ALU_MDU_DIV_EN is defined for the build.
module tb_ex_alu_mdu;

  localparam int W = 32;
`ifdef EX_ALU_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111, SLTU = 4'b1000, NOR_ = 4'b1100;
  localparam logic [3:0] MULT = 4'b1001, MULTU = 4'b1010, DIV = 4'b1011, DIVU = 4'b1101;
  localparam logic [3:0] MFHI = 4'b1110, MFLO = 4'b1111;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [W-1:0] a_s, b_s;
  logic [3:0]   op_s;
  logic         valid_s, flush_s;
  logic [W-1:0] ALU_Result_EX;
  logic         Zero_EX, Stall_EX, Illegal_EX;

  always #5 Clk = ~Clk;

  ex_alu_mdu #(.WIDTH(W)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Read_Data_1_EX(a_s),
    .ALU_Data_2_EX (b_s),
    .ALU_Control_EX(op_s),
    .Valid_EX      (valid_s),
    .Flush_EX      (flush_s),
    .ALU_Result_EX (ALU_Result_EX),
    .Zero_EX       (Zero_EX),
    .Stall_EX      (Stall_EX),
    .Illegal_EX    (Illegal_EX)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         valid;
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
  } vec_t;

  vec_t         vecs[16];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic v, input logic f);
    op_s = o; a_s = x; b_s = y; valid_s = v; flush_s = f;
  endtask

  // Reference: plain arithmetic on the architectural rules.
  function automatic logic [63:0] ref_mdu(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic signed [63:0] sx, sy;
    logic        [63:0] ux, uy;
    logic signed [31:0] qx, qy;
    sx = $signed(x); sy = $signed(y);
    ux = {32'h0, x}; uy = {32'h0, y};
    qx = $signed(x); qy = $signed(y);
    case (o)
      MULT:  return sx * sy;
      MULTU: return ux * uy;
      DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(qx % qy), 32'(qx / qy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [32:0] ref_alu(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic v);
    logic [W-1:0] r;
    logic         il;
    r = '0; il = 1'b0;
    case (o)
      ADD:         r = x + y;
      SUB:         r = x - y;
      AND_:        r = x & y;
      OR_:         r = x | y;
      NOR_:        r = ~(x | y);
      SLT:         r = ($signed(x) < $signed(y)) ? 1 : 0;
      SLTU:        r = (x < y) ? 1 : 0;
      MULT, MULTU: r = '0;
      DIV, DIVU:   il = !DIV_EN;
      MFHI:        r = m_hi;
      MFLO:        r = m_lo;
      default:     il = 1'b1;
    endcase
    return {il & v, r};
  endfunction

  task automatic check_hilo(input string tag);
    drive(MFHI, 32'h0, 32'h0, 1'b1, 1'b0);
    settle();
    chk({tag, "_mfhi_stall"}, 32'(Stall_EX), 32'd0);
    chk({tag, "_mfhi"}, ALU_Result_EX, m_hi);
    tick();
    drive(MFLO, 32'h0, 32'h0, 1'b1, 1'b0);
    settle();
    chk({tag, "_mflo"}, ALU_Result_EX, m_lo);
    tick();
    drive(AND_, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic run_mdu(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    logic [63:0] exp;
    int          hi_cnt;
    drive(o, x, y, 1'b1, 1'b0);
    settle();
    if ((o == DIV || o == DIVU) && !DIV_EN) begin
      chk({tag, "_illegal"}, 32'(Illegal_EX), 32'd1);
      chk({tag, "_nostall"}, 32'(Stall_EX), 32'd0);
      chk({tag, "_result"}, ALU_Result_EX, 32'd0);
      tick();
    end else begin
      chk({tag, "_result_zero"}, {ALU_Result_EX[30:0], Zero_EX}, 32'd1);
      hi_cnt = 0;
      for (int i = 0; i < W + 2; i++) begin
        if (i != 0) settle();
        if (Stall_EX) hi_cnt++;
        tick();
      end
      chk({tag, "_stall_cycles"}, 32'(hi_cnt), 32'(W + 2));
      exp  = ref_mdu(o, x, y);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
    check_hilo(tag);
    $display("mdu %s op=%b a=%h b=%h hi=%h lo=%h", tag, o, x, y, m_hi, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   sops[11];
    logic [3:0]   mops[4];
    logic [32:0]  ex;
    logic [3:0]   o;
    logic [W-1:0] x, y;
    logic         v;

    vecs[0]  = '{SLT,     32'hFFFF_FFFF, 32'h1,         1'b1, 32'h1,         1'b0, 1'b0};
    vecs[1]  = '{SLTU,    32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         1'b1, 1'b0};
    vecs[2]  = '{SUB,     32'h5,         32'h5,         1'b1, 32'h0,         1'b1, 1'b0};
    vecs[3]  = '{ADD,     32'hFFFF_FFFF, 32'h1,         1'b1, 32'h0,         1'b1, 1'b0};
    vecs[4]  = '{ADD,     32'h7,         32'h8,         1'b1, 32'hF,         1'b0, 1'b0};
    vecs[5]  = '{SUB,     32'h0,         32'h1,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6]  = '{AND_,    32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 1'b0};
    vecs[7]  = '{OR_,     32'hF0F0_F0F0, 32'h0F0F_0000, 1'b1, 32'hFFFF_F0F0, 1'b0, 1'b0};
    vecs[8]  = '{NOR_,    32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{SLT,     32'h1,         32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 1'b0};
    vecs[10] = '{SLT,     32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h1,         1'b0, 1'b0};
    vecs[11] = '{SLTU,    32'h1,         32'hFFFF_FFFF, 1'b1, 32'h1,         1'b0, 1'b0};
    vecs[12] = '{4'b0011, 32'h9,         32'h9,         1'b1, 32'h0,         1'b1, 1'b1};
    vecs[13] = '{4'b0101, 32'h9,         32'h9,         1'b0, 32'h0,         1'b1, 1'b0};
    vecs[14] = '{4'b0100, 32'h1,         32'h2,         1'b1, 32'h0,         1'b1, 1'b1};
    vecs[15] = '{MULT,    32'h3,         32'h4,         1'b0, 32'h0,         1'b1, 1'b0};

    sops = '{ADD, SUB, AND_, OR_, NOR_, SLT, SLTU, MFHI, MFLO, 4'b0011, 4'b0100};
    mops = '{MULT, MULTU, DIV, DIVU};

    // Reset behaviour
    Reset_n = 1'b0;
    drive(ADD, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    settle();
    chk("reset_stall", 32'(Stall_EX), 32'd0);
    chk("reset_illegal", 32'(Illegal_EX), 32'd0);
    chk("reset_result", ALU_Result_EX, 32'd0);
    chk("reset_zero", 32'(Zero_EX), 32'd1);
    tick();
    drive(4'b0011, 32'h0, 32'h0, 1'b1, 1'b0);
    settle();
    chk("reset_illegal_gated", 32'(Illegal_EX), 32'd0);
    tick();
    Reset_n = 1'b1;
    drive(AND_, 32'h0, 32'h0, 1'b0, 1'b0);
    check_hilo("post_reset");

    // Table-driven single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].valid, 1'b0);
      settle();
      chk("vec_result", ALU_Result_EX, vecs[i].res);
      chk("vec_zero", 32'(Zero_EX), 32'(vecs[i].zero));
      chk("vec_illegal", 32'(Illegal_EX), 32'(vecs[i].ill));
      chk("vec_stall", 32'(Stall_EX), 32'd0);
      $display("vec %0d op=%b a=%h b=%h res=%h", i, vecs[i].op, vecs[i].a, vecs[i].b, ALU_Result_EX);
      tick();
    end

    // Directed MDU cases
    run_mdu("mult_neg", MULT, 32'hFFFF_FFFE, 32'h3);
    run_mdu("div_neg", DIV, 32'hFFFF_FFF9, 32'h2);
    run_mdu("divu_zero", DIVU, 32'h1234, 32'h0);
    run_mdu("div_min", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mdu("div_zero_neg", DIV, 32'hFFFF_FF00, 32'h0);

    // Flush during RUN cycle 5 leaves HI/LO untouched
    drive(MULTU, 32'h1_0000, 32'h1_0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    flush_s = 1'b1;
    settle();
    chk("flush_run_stall", 32'(Stall_EX), 32'd1);
    tick();
    drive(AND_, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("flush_stall_drop", 32'(Stall_EX), 32'd0);
    tick();
    check_hilo("after_flush");
    run_mdu("multu_rerun", MULTU, 32'h1_0000, 32'h1_0000);

    // Flush in the launch cycle wins
    drive(MULT, 32'h5, 32'h6, 1'b1, 1'b1);
    settle();
    chk("flush_launch_stall", 32'(Stall_EX), 32'd0);
    tick();
    drive(AND_, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("flush_launch_idle", 32'(Stall_EX), 32'd0);
    tick();
    check_hilo("flush_launch");

    // Random single-cycle ops
    for (int i = 0; i < 24; i++) begin
      o = sops[$urandom_range(0, 10)];
      x = $urandom();
      y = ($urandom_range(0, 3) == 0) ? x : 32'($urandom());
      v = ($urandom_range(0, 4) != 0);
      ex = ref_alu(o, x, y, v);
      drive(o, x, y, v, 1'b0);
      settle();
      chk("rnd_result", ALU_Result_EX, ex[31:0]);
      chk("rnd_zero", 32'(Zero_EX), 32'(ex[31:0] == 0));
      chk("rnd_illegal", 32'(Illegal_EX), 32'(ex[32]));
      chk("rnd_stall", 32'(Stall_EX), 32'd0);
      $display("rnd op=%b a=%h b=%h v=%0d res=%h", o, x, y, v, ALU_Result_EX);
      tick();
    end

    // Random MDU ops with occasional boundary operands
    for (int i = 0; i < 14; i++) begin
      o = mops[$urandom_range(0, 3)];
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 100); y = $urandom_range(1, 9); end
        3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      run_mdu("rnd_mdu", o, x, y);
    end

    // Reset at RUN cycle 10 aborts and clears HI/LO
    run_mdu("pre_reset", MULT, 32'h1234_5678, 32'h9ABC_DEF1);
    drive(MULT, 32'h7, 32'h9, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    drive(AND_, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("midrun_reset_stall", 32'(Stall_EX), 32'd0);
    tick();
    m_hi = '0;
    m_lo = '0;
    check_hilo("midrun_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
